// File: rtl/aes_key_schedule_seq_if.sv
// Request/status/read-port bundle for the sequential AES key-schedule engine.
// NK must match the engine instance it is connected to.
interface aes_key_schedule_seq_if #(
    parameter int NK = 4
);
    logic              start;
    logic [32*NK-1:0]  key_in;
    logic              busy;
    logic              done;
    logic              keys_valid;
    logic [3:0]        rk_idx;
    logic [127:0]      rk_out;

    modport master (
        output start, key_in, rk_idx,
        input  busy, done, keys_valid, rk_out
    );

    modport slave (
        input  start, key_in, rk_idx,
        output busy, done, keys_valid, rk_out
    );
endinterface

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128/192/256 key expansion: one schedule word per clock through a
// shared four-S-box SubWord unit, read back as indexed 128-bit round keys.
module aes_key_schedule_seq #(
    parameter int NK = 4
) (
    input logic                   clk,
    input logic                   rst,
    aes_key_schedule_seq_if.slave bus
);
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] EXPAND = 1'b1;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gmul(b, b);
        x3   = gmul(x2, b);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        x252 = gmul(x240, x12);
        inv  = gmul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [0:0]   state;
    logic [5:0]   i;
    logic [2:0]   phase;
    logic [7:0]   rcon;
    logic [31:0]  w [NW];

    logic [31:0]  prev;
    logic [31:0]  back;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic [31:0]  temp;
    logic [31:0]  next_word;
    logic [5:0]   rd_base;
    logic [127:0] rk_next;

    always_comb begin
        prev    = w[i - 6'd1];
        back    = w[i - 6'(NK)];
        sub_in  = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                   sbox(sub_in[15:8]),  sbox(sub_in[7:0])};
        if (phase == 3'd0) begin
            temp = sub_out ^ {rcon, 24'h000000};
        end else if (NK == 8 && phase == 3'd4) begin
            temp = sub_out;
        end else begin
            temp = prev;
        end
        next_word = back ^ temp;
    end

    always_comb begin
        rd_base = {bus.rk_idx, 2'b00};
        if (bus.rk_idx > 4'(NR)) begin
            rk_next = '0;
        end else begin
            rk_next = {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            i              <= '0;
            phase          <= '0;
            rcon           <= 8'h01;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.keys_valid <= 1'b0;
            bus.rk_out     <= '0;
            for (int j = 0; j < NW; j++) w[j] <= '0;
        end else begin
            bus.done   <= 1'b0;
            bus.rk_out <= rk_next;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        for (int j = 0; j < NK; j++) w[j] <= bus.key_in[32*(NK-j)-1 -: 32];
                        i              <= 6'(NK);
                        phase          <= '0;
                        rcon           <= 8'h01;
                        bus.keys_valid <= 1'b0;
                        bus.busy       <= 1'b1;
                        state          <= EXPAND;
                    end
                end
                EXPAND: begin
                    w[i]  <= next_word;
                    i     <= i + 6'd1;
                    // phase tracks i mod NK without a divider
                    phase <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
                    if (phase == 3'd0) rcon <= xtime(rcon);
                    if (i == 6'(NW - 1)) begin
                        bus.busy       <= 1'b0;
                        bus.done       <= 1'b1;
                        bus.keys_valid <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Scoreboard bench: stimulus pushes expected read results and done edges; a monitor
// pops and compares them as the three engines (NK = 4, 6, 8) present outputs.
module tb_aes_key_schedule_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_key_schedule_seq_if #(.NK(4)) if4 ();
    aes_key_schedule_seq_if #(.NK(6)) if6 ();
    aes_key_schedule_seq_if #(.NK(8)) if8 ();

    aes_key_schedule_seq #(.NK(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
    aes_key_schedule_seq #(.NK(6)) dut6 (.clk(clk), .rst(rst), .bus(if6));
    aes_key_schedule_seq #(.NK(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] KB   = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K192 =
        256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    typedef struct {
        int           dut;
        logic [127:0] rk;
        bit           chk_rk;
        logic [2:0]   st;
        bit           chk_st;
        string        name;
    } rd_t;

    typedef struct {
        int dut;
        int at;
    } done_t;

    rd_t   rq[$];
    done_t dq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    rd_req = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rk_of(input int d);
        case (d)
            4:       return if4.rk_out;
            6:       return if6.rk_out;
            default: return if8.rk_out;
        endcase
    endfunction

    function automatic logic [2:0] st_of(input int d);
        case (d)
            4:       return {if4.busy, if4.done, if4.keys_valid};
            6:       return {if6.busy, if6.done, if6.keys_valid};
            default: return {if8.busy, if8.done, if8.keys_valid};
        endcase
    endfunction

    // Monitor: outputs are sampled 1 time unit after each rising edge.
    initial begin
        rd_t   it;
        done_t de;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rd_req) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_underflow: got empty queue required an entry");
                end else begin
                    it = rq.pop_front();
                    if (it.chk_rk) chk(it.name, rk_of(it.dut), it.rk);
                    if (it.chk_st) chk({it.name, "_status"}, 128'(st_of(it.dut)), 128'(it.st));
                end
            end
            for (int d = 4; d <= 8; d += 2) begin
                if (st_of(d)[1]) begin
                    if (dq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected: got done on NK=%0d at edge %0d required none",
                                 d, cyc);
                    end else begin
                        de = dq.pop_front();
                        chk($sformatf("done_dut_nk%0d", d), 128'(d), 128'(de.dut));
                        chk($sformatf("done_edge_nk%0d", d), 128'(cyc), 128'(de.at));
                    end
                end
            end
        end
    end

    // Caller sits at a negedge; start is sampled on the following rising edge.
    task automatic drive_start(input int d, input logic [255:0] key, input bit expect_done);
        done_t de;
        case (d)
            4: begin if4.key_in = key[127:0]; if4.start = 1'b1; end
            6: begin if6.key_in = key[191:0]; if6.start = 1'b1; end
            default: begin if8.key_in = key; if8.start = 1'b1; end
        endcase
        if (expect_done) begin
            de.dut = d;
            de.at  = cyc + 1 + 3 * d + 28;
            dq.push_back(de);
        end
    endtask

    task automatic clr_start();
        if4.start = 1'b0;
        if6.start = 1'b0;
        if8.start = 1'b0;
    endtask

    // Present one read for the next edge and queue its expectation.
    task automatic issue(input int d, input int idx, input logic [127:0] exp, input bit chk_rk,
                         input logic [2:0] st, input bit chk_st, input string name);
        rd_t it;
        case (d)
            4:       if4.rk_idx = 4'(idx);
            6:       if6.rk_idx = 4'(idx);
            default: if8.rk_idx = 4'(idx);
        endcase
        it.dut = d; it.rk = exp; it.chk_rk = chk_rk;
        it.st = st; it.chk_st = chk_st; it.name = name;
        rq.push_back(it);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic wait_idle(input int d, input string name);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!st_of(d)[2]) break;
        end
        chk({name, "_idle"}, 128'(st_of(d)[2]), 128'(0));
    endtask

    initial begin
        clr_start();
        if4.key_in = '0; if6.key_in = '0; if8.key_in = '0;
        if4.rk_idx = '0; if6.rk_idx = '0; if8.rk_idx = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        issue(4, 0, 128'h0, 1, 3'b000, 1, "reset_nk4");
        issue(6, 0, 128'h0, 1, 3'b000, 1, "reset_nk6");
        issue(8, 0, 128'h0, 1, 3'b000, 1, "reset_nk8");

        // AES-128 with exact status at the accepting edge and around done.
        drive_start(4, K128, 1);
        issue(4, 0, 128'h0, 0, 3'b100, 1, "aes128_accept");
        clr_start();
        repeat (38) @(negedge clk);
        issue(4, 0, 128'h0, 0, 3'b100, 1, "aes128_before_done");
        issue(4, 0, 128'h0, 0, 3'b011, 1, "aes128_done");
        issue(4, 1, 128'ha0fafe1788542cb123a339392a6c7605, 1, 3'b001, 1, "aes128_rk1");
        issue(4, 2, 128'hf2c295f27a96b9435935807a7359f67f, 1, 3'b000, 0, "aes128_rk2");
        issue(4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1, 3'b000, 0, "aes128_rk10");
        issue(4, 0, K128[127:0], 1, 3'b000, 0, "aes128_rk0");
        issue(4, 11, 128'h0, 1, 3'b000, 0, "aes128_rk11_zero");

        // Second start at k+10 with another key must be ignored.
        drive_start(4, K128, 1);
        issue(4, 0, 128'h0, 0, 3'b100, 1, "ignore_accept");
        clr_start();
        repeat (9) @(negedge clk);
        drive_start(4, KB, 0);
        @(negedge clk);
        clr_start();
        wait_idle(4, "ignore");
        issue(4, 0, K128[127:0], 1, 3'b001, 1, "ignore_rk0");
        issue(4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1, 3'b000, 0, "ignore_rk10");

        // Asynchronous reset at edge k+20.
        drive_start(4, K128, 0);
        if4.rk_idx = 4'd0;
        @(negedge clk);
        clr_start();
        repeat (20) @(posedge clk);
        #2;
        chk("abort_pre_rk0", if4.rk_out, K128[127:0]);
        chk("abort_pre_busy", 128'(if4.busy), 128'(1));
        rst = 1'b1;
        #1;
        chk("abort_busy", 128'(if4.busy), 128'(0));
        chk("abort_done", 128'(if4.done), 128'(0));
        chk("abort_keys_valid", 128'(if4.keys_valid), 128'(0));
        chk("abort_rk_out", if4.rk_out, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive_start(4, K128, 1);
        issue(4, 0, 128'h0, 0, 3'b100, 1, "fresh_accept");
        clr_start();
        wait_idle(4, "fresh");
        issue(4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1, 3'b001, 1, "fresh_rk10");

        // Start held high through done: a second expansion follows immediately.
        begin
            done_t de;
            de.dut = 4;
            de.at  = cyc + 1 + 41 + 40;
            drive_start(4, K128, 1);
            dq.push_back(de);
        end
        issue(4, 0, 128'h0, 0, 3'b100, 1, "b2b_accept");
        repeat (38) @(negedge clk);
        issue(4, 0, 128'h0, 0, 3'b100, 1, "b2b_before_done");
        issue(4, 0, 128'h0, 0, 3'b011, 1, "b2b_done");
        issue(4, 0, 128'h0, 0, 3'b100, 1, "b2b_reaccept");
        clr_start();
        wait_idle(4, "b2b");
        issue(4, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1, 3'b001, 1, "b2b_rk10");

        // AES-192
        drive_start(6, K192, 1);
        issue(6, 0, 128'h0, 0, 3'b100, 1, "aes192_accept");
        clr_start();
        wait_idle(6, "aes192");
        issue(6, 0, K192[191:64], 1, 3'b001, 1, "aes192_rk0");
        issue(6, 1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5, 1, 3'b000, 0, "aes192_rk1");
        issue(6, 12, 128'he98ba06f448c773c8ecc720401002202, 1, 3'b000, 0, "aes192_rk12");
        issue(6, 13, 128'h0, 1, 3'b000, 0, "aes192_rk13_zero");

        // AES-256
        drive_start(8, K256, 1);
        issue(8, 0, 128'h0, 0, 3'b100, 1, "aes256_accept");
        clr_start();
        wait_idle(8, "aes256");
        issue(8, 1, K256[127:0], 1, 3'b001, 1, "aes256_rk1");
        issue(8, 3, 128'ha8b09c1a93d194cdbe49846eb75d5b9a, 1, 3'b000, 0, "aes256_rk3");
        issue(8, 14, 128'hfe4890d1e6188d0b046df344706c631e, 1, 3'b000, 0, "aes256_rk14");
        issue(8, 15, 128'h0, 1, 3'b000, 0, "aes256_rk15_zero");

        repeat (3) @(negedge clk);
        chk("pending_done", 128'(dq.size()), 128'(0));
        chk("pending_reads", 128'(rq.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by time %0t required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/aes_key_schedule_seq.md
# aes_key_schedule_seq

Sequential, parametrised AES key-expansion engine for AES-128, AES-192 and AES-256. It generates one 32-bit schedule word per clock into an internal word store, using a single shared SubWord unit of four S-boxes. It exposes the result as indexed 128-bit round keys through a registered read port, so the cipher datapath can fetch round keys on demand instead of carrying a flat all-keys bus.

## Interface
- NK, default 4: key length in 32-bit words; legal values 4, 6, 8. Derived localparams: NR = NK+6 (rounds); NW = 4*(NR+1) (schedule words: 44/52/60).
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request expansion of key_in; sampled only in IDLE.
- key_in  in  32*NK  cipher key; word 0 = key_in[32*NK-1 -: 32]; sampled on the accepting edge only.
- busy  out  1  high while expansion is in progress.
- done  out  1  single-cycle pulse when the last word is written.
- keys_valid  out  1  schedule complete and readable.
- rk_idx  in  4  round-key index, 0..NR.
- rk_out  out  128  round key rk_idx: {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] at [127:96]; registered.

## Operation
- States: IDLE, EXPAND.
- IDLE with start=1: w[0..NK-1] <= key_in, i <= NK, rcon <= 8'h01, keys_valid <= 0, busy <= 1, go to EXPAND.
- EXPAND, each edge: temp = w[i-1].
  - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon <= xtime(rcon). Sequence: 01,02,04,08,10,20,40,80,1b,36.
  - Else if NK==8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] <= w[i-NK] ^ temp; i <= i+1.
- On the edge writing w[NW-1]: busy <= 0, done <= 1, keys_valid <= 1, go to IDLE.
- done is cleared on the following edge.
- start is ignored while busy; key_in has no effect after acceptance.
- keys_valid stays high until the next accepted start or reset. A new start clears it on the accepting edge.
- Read port: rk_out <= round key rk_idx each edge, regardless of state. If rk_idx > NR, rk_out <= 0. Contents while keys_valid=0 are don't-care, except after reset, when they are 0.
- i is a 6-bit counter; the i mod NK computation uses a separate wrapping phase counter (0..NK-1), not a divider.

## Timing
- Reset values: busy=0, done=0, keys_valid=0, rk_out=0, state IDLE, all words 0, rcon=01.
- Let edge k accept start. Edges k+1 .. k+(NW-NK) write words NK .. NW-1.
  - done, keys_valid and busy fall all change on edge k+(NW-NK): k+40 for NK=4, k+46 for NK=6, k+52 for NK=8.
- busy rises on edge k.
- Read latency is 1 cycle: rk_idx presented before edge n gives rk_out valid after edge n.
- A start asserted in the same cycle that done is high (state already IDLE) is accepted.
- rst asserted mid-expansion aborts immediately to the reset values above. No partial result is reported.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle:
  - done exactly 40 edges after acceptance.
  - rk_idx=1 -> a0fafe1788542cb123a339392a6c7605.
  - rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 (NK=6), key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done after 46 edges.
  - rk_idx=12 -> e98ba06f448c773c8ecc720401002202.
- AES-256 (NK=8), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done after 52 edges.
  - rk_idx=14 -> fe4890d1e6188d0b046df344706c631e, which exercises the i mod 8 == 4 SubWord.
- Start pulsed again at edge k+10 with a different key_in:
  - ignored; AES-128 results identical to scenario 1.
  - rk_idx=0 returns the original key.
- rst asserted at edge k+20 of an expansion:
  - busy, done, keys_valid and rk_out go to 0 asynchronously.
  - A fresh start then completes normally with correct keys.
- rk_idx=11 with NK=4 -> rk_out=0.
- Back-to-back run: start held high through the done cycle -> second expansion accepted, and keys_valid drops on that edge.
